// File: rtl/branch_resolve_unit.sv
// Multi-channel branch resolver: one-cycle result per channel, output held while res_ready=0,
// oldest mispredict of the cycle redirects fetch and squashes younger results. BRANCH_STATS_EN adds counters.
`ifndef BRANCH_TYPE_BEQ
`define BRANCH_TYPE_BEQ  4'd0
`define BRANCH_TYPE_BNE  4'd1
`define BRANCH_TYPE_BGEZ 4'd2
`define BRANCH_TYPE_BLTZ 4'd3
`define BRANCH_TYPE_J    4'd4
`define BRANCH_TYPE_JAL  4'd5
`define BRANCH_TYPE_JR   4'd6
`endif
`ifndef BRANCH_TYPE_BLEZ
`define BRANCH_TYPE_BLEZ 4'd7
`define BRANCH_TYPE_BGTZ 4'd8
`define BRANCH_TYPE_JALR 4'd9
`endif

module branch_resolve_unit #(
  parameter int          NUM_BRANCH  = 2,
  parameter int          ROB_IDX_W   = 7,
  parameter logic [31:0] LINK_OFFSET = 32'd8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_BRANCH-1:0]                 in_valid,
  output logic [NUM_BRANCH-1:0]                 in_ready,
  input  logic [NUM_BRANCH-1:0][31:0]           in_src1,
  input  logic [NUM_BRANCH-1:0][31:0]           in_src2,
  input  logic [NUM_BRANCH-1:0][31:0]           in_pc,
  input  logic [NUM_BRANCH-1:0][31:0]           in_br_target,
  input  logic [NUM_BRANCH-1:0][31:0]           in_j_target,
  input  logic [NUM_BRANCH-1:0][3:0]            in_type,
  input  logic [NUM_BRANCH-1:0]                 in_pred_taken,
  input  logic [NUM_BRANCH-1:0][31:0]           in_pred_target,
  input  logic [NUM_BRANCH-1:0][ROB_IDX_W-1:0]  in_rob_idx,
  input  logic [ROB_IDX_W-1:0]                  rob_head,
  input  logic                                  flush,
  output logic [NUM_BRANCH-1:0]                 res_valid,
  input  logic [NUM_BRANCH-1:0]                 res_ready,
  output logic [NUM_BRANCH-1:0]                 res_taken,
  output logic [NUM_BRANCH-1:0][31:0]           res_target,
  output logic [NUM_BRANCH-1:0][31:0]           res_link,
  output logic [NUM_BRANCH-1:0]                 res_link_we,
  output logic [NUM_BRANCH-1:0]                 res_mispred,
  output logic [NUM_BRANCH-1:0][ROB_IDX_W-1:0]  res_rob_idx,
  output logic                                  redirect_valid,
  output logic [31:0]                           redirect_pc,
  output logic [ROB_IDX_W-1:0]                  redirect_rob_idx
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]                           stat_resolved,
  output logic [31:0]                           stat_mispred
`endif
);

  logic [NUM_BRANCH-1:0]                res_valid_q, res_valid_d;
  logic [NUM_BRANCH-1:0]                res_taken_q;
  logic [NUM_BRANCH-1:0][31:0]          res_target_q;
  logic [NUM_BRANCH-1:0][31:0]          res_link_q;
  logic [NUM_BRANCH-1:0]                res_link_we_q;
  logic [NUM_BRANCH-1:0]                res_mispred_q;
  logic [NUM_BRANCH-1:0][ROB_IDX_W-1:0] res_rob_idx_q;
  logic                                 redirect_valid_q;
  logic [31:0]                          redirect_pc_q;
  logic [ROB_IDX_W-1:0]                 redirect_rob_idx_q;

  logic [NUM_BRANCH-1:0]                acc, taken, is_cond, link_we, mispred, load;
  logic [NUM_BRANCH-1:0][31:0]          target, link;
  logic [NUM_BRANCH-1:0][ROB_IDX_W-1:0] age_in, age_held;

  logic                                 sel_vld;
  logic [ROB_IDX_W-1:0]                 sel_age;
  logic [31:0]                          sel_pc;
  logic [ROB_IDX_W-1:0]                 sel_rob;

  assign in_ready = ~res_valid_q | res_ready;

  always_comb begin
    for (int c = 0; c < NUM_BRANCH; c++) begin
      taken[c]   = 1'b0;
      is_cond[c] = 1'b1;
      link_we[c] = 1'b0;
      target[c]  = in_pc[c] + 32'd4;
      case (in_type[c])
        `BRANCH_TYPE_BEQ:  taken[c] = (in_src1[c] == in_src2[c]);
        `BRANCH_TYPE_BNE:  taken[c] = (in_src1[c] != in_src2[c]);
        `BRANCH_TYPE_BGEZ: taken[c] = !in_src1[c][31];
        `BRANCH_TYPE_BLTZ: taken[c] = in_src1[c][31];
        `BRANCH_TYPE_BLEZ: taken[c] = in_src1[c][31] || (in_src1[c] == 32'd0);
        `BRANCH_TYPE_BGTZ: taken[c] = !in_src1[c][31] && (in_src1[c] != 32'd0);
        `BRANCH_TYPE_J, `BRANCH_TYPE_JAL: begin
          taken[c]   = 1'b1;
          is_cond[c] = 1'b0;
          target[c]  = in_j_target[c];
          link_we[c] = (in_type[c] == `BRANCH_TYPE_JAL);
        end
        `BRANCH_TYPE_JR, `BRANCH_TYPE_JALR: begin
          taken[c]   = 1'b1;
          is_cond[c] = 1'b0;
          target[c]  = in_src1[c];
          link_we[c] = (in_type[c] == `BRANCH_TYPE_JALR);
        end
        default: ;
      endcase
      if (is_cond[c] && taken[c]) begin
        target[c] = in_br_target[c];
      end
      mispred[c]  = (taken[c] != in_pred_taken[c]) ||
                    (taken[c] && (target[c] != in_pred_target[c]));
      link[c]     = in_pc[c] + LINK_OFFSET;
      acc[c]      = in_valid[c] && in_ready[c];
      // Ages wrap with the ROB index, so plain modular subtraction orders them.
      age_in[c]   = in_rob_idx[c] - rob_head;
      age_held[c] = res_rob_idx_q[c] - rob_head;
    end
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_age = '0;
    sel_pc  = '0;
    sel_rob = '0;
    for (int c = 0; c < NUM_BRANCH; c++) begin
      if (acc[c] && mispred[c] && (!sel_vld || (age_in[c] < sel_age))) begin
        sel_vld = 1'b1;
        sel_age = age_in[c];
        sel_pc  = target[c];
        sel_rob = in_rob_idx[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_BRANCH; c++) begin
      load[c] = acc[c] && !flush && !(sel_vld && (age_in[c] > sel_age));
      if (flush) begin
        res_valid_d[c] = 1'b0;
      end else if (load[c]) begin
        res_valid_d[c] = 1'b1;
      end else if (res_valid_q[c] && res_ready[c]) begin
        res_valid_d[c] = 1'b0;
      end else if (res_valid_q[c] && sel_vld && (age_held[c] > sel_age)) begin
        res_valid_d[c] = 1'b0;
      end else begin
        res_valid_d[c] = res_valid_q[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q        <= '0;
      res_taken_q        <= '0;
      res_target_q       <= '0;
      res_link_q         <= '0;
      res_link_we_q      <= '0;
      res_mispred_q      <= '0;
      res_rob_idx_q      <= '0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      redirect_rob_idx_q <= '0;
    end else begin
      res_valid_q      <= res_valid_d;
      redirect_valid_q <= sel_vld && !flush;
      if (sel_vld && !flush) begin
        redirect_pc_q      <= sel_pc;
        redirect_rob_idx_q <= sel_rob;
      end
      for (int c = 0; c < NUM_BRANCH; c++) begin
        if (load[c]) begin
          res_taken_q[c]   <= taken[c];
          res_target_q[c]  <= target[c];
          res_link_q[c]    <= link[c];
          res_link_we_q[c] <= link_we[c];
          res_mispred_q[c] <= mispred[c];
          res_rob_idx_q[c] <= in_rob_idx[c];
        end
      end
    end
  end

  assign res_valid        = res_valid_q;
  assign res_taken        = res_taken_q;
  assign res_target       = res_target_q;
  assign res_link         = res_link_q;
  assign res_link_we      = res_link_we_q;
  assign res_mispred      = res_mispred_q;
  assign res_rob_idx      = res_rob_idx_q;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign redirect_rob_idx = redirect_rob_idx_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;
  logic [2:0]  n_load, n_misp;
  logic [32:0] sum_res, sum_misp;

  // Counters saturate rather than wrap so a long run never reads as a small count.
  always_comb begin
    n_load = '0;
    n_misp = '0;
    for (int c = 0; c < NUM_BRANCH; c++) begin
      n_load = n_load + {2'b00, load[c]};
      n_misp = n_misp + {2'b00, load[c] && mispred[c]};
    end
    sum_res         = {1'b0, stat_resolved_q} + {30'd0, n_load};
    sum_misp        = {1'b0, stat_mispred_q} + {30'd0, n_misp};
    stat_resolved_d = sum_res[32] ? 32'hFFFF_FFFF : sum_res[31:0];
    stat_mispred_d  = sum_misp[32] ? 32'hFFFF_FFFF : sum_misp[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios then randomized traffic, all checked against
// a transaction-level model of resolution, redirect selection, squash and flush.
module tb_branch_resolve_unit;
  localparam int NB = 2;
  localparam int W  = 7;

  localparam bit [3:0] T_BEQ = 4'd0, T_BNE = 4'd1, T_BGEZ = 4'd2, T_BLTZ = 4'd3,
                       T_J = 4'd4, T_JAL = 4'd5, T_JR = 4'd6,
                       T_BLEZ = 4'd7, T_BGTZ = 4'd8, T_JALR = 4'd9;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NB-1:0]        in_valid, in_ready, in_pred_taken;
  logic [NB-1:0][31:0]  in_src1, in_src2, in_pc, in_br_target, in_j_target, in_pred_target;
  logic [NB-1:0][3:0]   in_type;
  logic [NB-1:0][W-1:0] in_rob_idx;
  logic [W-1:0]         rob_head;
  logic                 flush;
  logic [NB-1:0]        res_valid, res_ready, res_taken, res_link_we, res_mispred;
  logic [NB-1:0][31:0]  res_target, res_link;
  logic [NB-1:0][W-1:0] res_rob_idx;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic [W-1:0]         redirect_rob_idx;
`ifdef BRANCH_STATS_EN
  logic [31:0]          stat_resolved, stat_mispred;
`endif

  branch_resolve_unit #(.NUM_BRANCH(NB), .ROB_IDX_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_pc(in_pc), .in_br_target(in_br_target),
    .in_j_target(in_j_target), .in_type(in_type), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .in_rob_idx(in_rob_idx), .rob_head(rob_head),
    .flush(flush), .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_target(res_target), .res_link(res_link), .res_link_we(res_link_we),
    .res_mispred(res_mispred), .res_rob_idx(res_rob_idx), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_rob_idx(redirect_rob_idx)
`ifdef BRANCH_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit          v;
    bit          taken;
    bit [31:0]   target;
    bit [31:0]   link;
    bit          lwe;
    bit          misp;
    bit [W-1:0]  rob;
  } res_t;

  res_t       m [NB];
  bit         m_rv;
  bit [31:0]  m_rpc;
  bit [W-1:0] m_ridx;
  int         m_nres, m_nmis;
  int         n_chk = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int age(input bit [W-1:0] x);
    return (int'(x) - int'(rob_head) + (1 << W)) % (1 << W);
  endfunction

  // Architectural meaning of the operation currently presented on channel c.
  function automatic res_t resolve(input int c);
    res_t r;
    int   s1, s2;
    bit   cond;
    s1   = $signed(in_src1[c]);
    s2   = $signed(in_src2[c]);
    r    = '0;
    cond = 1'b1;
    case (in_type[c])
      T_BEQ:  r.taken = (s1 == s2);
      T_BNE:  r.taken = (s1 != s2);
      T_BGEZ: r.taken = (s1 >= 0);
      T_BLTZ: r.taken = (s1 < 0);
      T_BLEZ: r.taken = (s1 <= 0);
      T_BGTZ: r.taken = (s1 > 0);
      T_J, T_JAL: begin r.taken = 1'b1; cond = 1'b0; r.target = in_j_target[c]; end
      T_JR, T_JALR: begin r.taken = 1'b1; cond = 1'b0; r.target = in_src1[c]; end
      default: r.taken = 1'b0;
    endcase
    if (cond) r.target = r.taken ? in_br_target[c] : in_pc[c] + 32'd4;
    r.link = in_pc[c] + 32'd8;
    r.lwe  = (in_type[c] == T_JAL) || (in_type[c] == T_JALR);
    r.misp = (r.taken != in_pred_taken[c]) || (r.taken && (r.target != in_pred_target[c]));
    r.rob  = in_rob_idx[c];
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NB; c++) m[c] = '0;
    m_rv = 1'b0; m_rpc = '0; m_ridx = '0;
    m_nres = 0; m_nmis = 0;
  endtask

  task automatic clear_inputs();
    in_valid = '0; in_src1 = '0; in_src2 = '0; in_pc = '0; in_br_target = '0;
    in_j_target = '0; in_type = '0; in_pred_taken = '0; in_pred_target = '0;
    in_rob_idx = '0; flush = 1'b0;
  endtask

  task automatic set_ch(input int c, input bit [3:0] t, input bit [31:0] s1, input bit [31:0] s2,
                        input bit [31:0] pc, input bit [31:0] brt, input bit [31:0] jt,
                        input bit pt, input bit [31:0] ptgt, input bit [W-1:0] tag);
    in_valid[c] = 1'b1; in_type[c] = t; in_src1[c] = s1; in_src2[c] = s2; in_pc[c] = pc;
    in_br_target[c] = brt; in_j_target[c] = jt; in_pred_taken[c] = pt;
    in_pred_target[c] = ptgt; in_rob_idx[c] = tag;
  endtask

  task automatic compare_outputs();
    for (int c = 0; c < NB; c++) begin
      chk("res_valid", res_valid[c], m[c].v);
      if (m[c].v) begin
        chk("res_taken", res_taken[c], m[c].taken);
        chk("res_target", res_target[c], m[c].target);
        chk("res_link", res_link[c], m[c].link);
        chk("res_link_we", res_link_we[c], m[c].lwe);
        chk("res_mispred", res_mispred[c], m[c].misp);
        chk("res_rob_idx", res_rob_idx[c], m[c].rob);
      end
    end
    chk("redirect_valid", redirect_valid, m_rv);
    if (m_rv) begin
      chk("redirect_pc", redirect_pc, m_rpc);
      chk("redirect_rob_idx", redirect_rob_idx, m_ridx);
    end
`ifdef BRANCH_STATS_EN
    chk("stat_resolved", stat_resolved, m_nres);
    chk("stat_mispred", stat_mispred, m_nmis);
`endif
  endtask

  // One clock: check handshake, advance the model from the presented inputs, then compare.
  task automatic cycle();
    res_t r [NB];
    bit   acc [NB];
    int   best, bage;
    @(negedge clk);
    best = -1;
    bage = 0;
    for (int c = 0; c < NB; c++) begin
      chk("in_ready", in_ready[c], !m[c].v || res_ready[c]);
      acc[c] = in_valid[c] && (!m[c].v || res_ready[c]);
      r[c]   = resolve(c);
      if (acc[c] && r[c].misp && (best < 0 || age(r[c].rob) < bage)) begin
        best = c;
        bage = age(r[c].rob);
      end
    end
    if (flush) begin
      for (int c = 0; c < NB; c++) m[c].v = 1'b0;
      m_rv = 1'b0;
    end else begin
      for (int c = 0; c < NB; c++) begin
        if (m[c].v && res_ready[c]) m[c].v = 1'b0;
        if (acc[c]) begin m[c] = r[c]; m[c].v = 1'b1; end
      end
      if (best >= 0) begin
        for (int c = 0; c < NB; c++)
          if (m[c].v && age(m[c].rob) > bage) m[c].v = 1'b0;
        m_rpc  = r[best].target;
        m_ridx = r[best].rob;
      end
      m_rv = (best >= 0);
      for (int c = 0; c < NB; c++) begin
        if (acc[c] && m[c].v) begin
          m_nres++;
          if (m[c].misp) m_nmis++;
        end
      end
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic rand_inputs();
    res_t r;
    bit [W-1:0] base;
    clear_inputs();
    base = W'($urandom);
    if ($urandom_range(0, 7) == 0) rob_head = W'($urandom);
    flush = ($urandom_range(0, 39) == 0);
    for (int c = 0; c < NB; c++) begin
      bit [31:0] s1;
      case ($urandom_range(0, 3))
        0: s1 = 32'd0;
        1: s1 = $urandom;
        2: s1 = -32'($urandom_range(1, 100));
        default: s1 = 32'($urandom_range(1, 100));
      endcase
      set_ch(c, 4'($urandom_range(0, 11)), s1, ($urandom_range(0, 1) == 1) ? s1 : $urandom,
             $urandom & ~32'h3, $urandom & ~32'h3, $urandom & ~32'h3, 1'b0, 32'd0, base + W'(c));
      in_valid[c]  = ($urandom_range(0, 3) != 0);
      res_ready[c] = ($urandom_range(0, 3) != 0);
      r = resolve(c);
      if ($urandom_range(0, 9) < 7) begin
        in_pred_taken[c]  = r.taken;
        in_pred_target[c] = r.taken ? r.target : $urandom;
      end else begin
        in_pred_taken[c]  = 1'($urandom);
        in_pred_target[c] = ($urandom_range(0, 1) == 1) ? r.target : $urandom;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rob_head = '0;
    res_ready = '1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_in_ready", in_ready, 2'b11);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_res_target", res_target, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    set_ch(0, T_BEQ, 5, 5, 32'h40, 32'h100, 0, 1'b1, 32'h100, 1);
    cycle();
    chk("t1_taken", res_taken[0], 1);
    chk("t1_target", res_target[0], 32'h100);
    chk("t1_mispred", res_mispred[0], 0);
    chk("t1_redirect", redirect_valid, 0);

    clear_inputs();
    set_ch(1, T_JALR, 32'h2000, 0, 32'h80, 0, 0, 1'b1, 32'h1FFC, 2);
    cycle();
    chk("t2_link", res_link[1], 32'h88);
    chk("t2_link_we", res_link_we[1], 1);
    chk("t2_mispred", res_mispred[1], 1);
    chk("t2_redirect_valid", redirect_valid, 1);
    chk("t2_redirect_pc", redirect_pc, 32'h2000);
    clear_inputs();
    cycle();
    chk("t2_redirect_pulse", redirect_valid, 0);

    rob_head = 7'd120;
    set_ch(0, T_BEQ, 1, 2, 32'h10, 32'h50, 0, 1'b1, 32'h50, 3);
    set_ch(1, T_BNE, 1, 1, 32'h20, 32'h60, 0, 1'b1, 32'h60, 125);
    cycle();
    chk("t3_redirect_idx", redirect_rob_idx, 125);
    chk("t3_ch0_dropped", res_valid[0], 0);
    chk("t3_ch1_kept", res_valid[1], 1);

    rob_head = 7'd0;
    clear_inputs();
    res_ready = 2'b10;
    set_ch(0, T_BEQ, 4, 4, 32'h30, 32'h90, 0, 1'b1, 32'h90, 10);
    cycle();
    clear_inputs();
    set_ch(1, T_BGTZ, 7, 0, 32'h34, 32'hA0, 0, 1'b0, 0, 8);
    cycle();
    chk("t4_held_cleared", res_valid[0], 0);
    chk("t4_redirect_idx", redirect_rob_idx, 8);

    clear_inputs();
    res_ready = 2'b00;
    set_ch(0, T_BLEZ, -32'sd3, 0, 32'h100, 32'h200, 0, 1'b1, 32'h200, 20);
    cycle();
    set_ch(0, T_BGEZ, 1, 0, 32'h104, 32'h300, 0, 1'b1, 32'h300, 21);
    repeat (3) begin
      cycle();
      chk("t5_stall_ready", in_ready[0], 0);
      chk("t5_stall_hold", res_rob_idx[0], 20);
    end
    res_ready = 2'b11;
    cycle();
    chk("t5_b2b", res_rob_idx[0], 21);

    clear_inputs();
    set_ch(0, T_J, 0, 0, 32'h10, 0, 32'h400, 1'b1, 32'h500, 30);
    set_ch(1, T_BLTZ, 5, 0, 32'h14, 32'h80, 0, 1'b0, 0, 31);
    flush = 1'b1;
    cycle();
    chk("t6_flush_valid", res_valid, 0);
    chk("t6_flush_redirect", redirect_valid, 0);

    clear_inputs();
    res_ready = 2'b00;
    set_ch(0, T_BNE, 1, 2, 32'h60, 32'h70, 0, 1'b1, 32'h70, 40);
    cycle();
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", res_valid, 0);
    chk("t7_rst_target", res_target, 0);
    chk("t7_rst_redirect", redirect_valid, 0);
    model_reset();
    clear_inputs();
    res_ready = 2'b11;
    #1 rst_n = 1'b1;

`ifdef BRANCH_STATS_EN
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      set_ch(0, T_BEQ, 3, 3, 32'h200, 32'h240, 0, 1'b1, (i == 2) ? 32'h0 : 32'h240, W'(50 + i));
      cycle();
    end
    clear_inputs();
    cycle();
    chk("stat_resolved_4", stat_resolved, 4);
    chk("stat_mispred_1", stat_mispred, 1);
`endif

    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Multi-channel branch resolution stage between IssueUnit and ROB/fetch-redirect logic.
- Generalises the single-channel, 1-cycle branch executor with:
  - NUM_BRANCH parallel channels, each with a valid/ready handshake and a backpressure-holding output register;
  - additional MIPS branch types and a link-value result;
  - age-ordered selection of a single fetch redirect, with same-cycle squash of younger results.

Parameters:
- NUM_BRANCH, 2, number of parallel resolution channels (1..4).
- ROB_IDX_W, 7, ROB index width; age is computed modulo 2^ROB_IDX_W.
- LINK_OFFSET, 8, added to pc to form the link value (delay-slot semantics).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  NUM_BRANCH  per-channel branch operation valid
- in_ready  out  NUM_BRANCH  per-channel accept; in_ready[c] = !res_valid[c] || res_ready[c]
- in_src1 / in_src2  in  32 x NUM_BRANCH  rs / rt values
- in_pc  in  32 x NUM_BRANCH  branch PC
- in_br_target  in  32 x NUM_BRANCH  PC-relative target
- in_j_target  in  32 x NUM_BRANCH  J-type target
- in_type  in  4 x NUM_BRANCH  `BRANCH_TYPE_* code
- in_pred_taken  in  NUM_BRANCH  predicted direction
- in_pred_target  in  32 x NUM_BRANCH  predicted target
- in_rob_idx  in  ROB_IDX_W x NUM_BRANCH  ROB tag
- rob_head  in  ROB_IDX_W  oldest in-flight ROB index, used for age ordering
- flush  in  1  synchronous pipeline flush
- res_valid  out  NUM_BRANCH  result held valid
- res_ready  in  NUM_BRANCH  consumer accepts result
- res_taken  out  NUM_BRANCH  actual direction
- res_target  out  32 x NUM_BRANCH  actual next PC
- res_link  out  32 x NUM_BRANCH  pc + LINK_OFFSET
- res_link_we  out  NUM_BRANCH  1 for JAL/JALR
- res_mispred  out  NUM_BRANCH  misprediction flag
- res_rob_idx  out  ROB_IDX_W x NUM_BRANCH  ROB tag
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  32  correct fetch PC
- redirect_rob_idx  out  ROB_IDX_W  tag of the redirecting branch

Behaviour:
- Reset: all res_* and redirect_* outputs are 0. in_ready is then all-ones.
- Accept condition for channel c: in_valid[c] && in_ready[c].
- Latency: an accepted operation appears on res_* at the next edge. The output register holds its value while res_valid && !res_ready.
- Direction decode:
  - BEQ: src1 == src2.
  - BNE: src1 != src2.
  - BGEZ: signed src1 >= 0.
  - BLTZ: signed src1 < 0.
  - BLEZ: signed src1 <= 0.
  - BGTZ: signed src1 > 0.
  - J, JAL, JR, JALR: always taken.
  - Unknown codes: not taken, res_mispred = in_pred_taken.
- BLEZ, BGTZ and JALR are added to BranchTypes.svh using the next free codes.
- Target:
  - Conditional branches: taken ? br_target : pc + 4.
  - J/JAL: j_target.
  - JR/JALR: src1.
- Mispredict: (taken != pred_taken) || (taken && target != pred_target).
- Age: age(x) = (x - rob_head) mod 2^ROB_IDX_W; a smaller age is older.
- Redirect selection: among channels accepted this cycle with mispredict set, pick the one with minimum age. Tags are unique, so there are no ties. At the next edge:
  - redirect_valid = 1 for exactly one cycle;
  - redirect_pc and redirect_rob_idx are set from the selected channel.
- Squash, applied at that same edge:
  - Any channel accepted this cycle whose age is greater than the selected branch is not loaded; its res_valid stays 0 and the operation is dropped.
  - Any result already held in an output register (stalled) whose age is greater than the selected branch is cleared.
  - Entries that are older, and the selected branch itself, are kept.
- Flush has priority over everything:
  - at the edge, all res_valid and redirect_valid clear;
  - operations presented in the same cycle are dropped;
  - in_ready follows its formula from the cleared state.
- Reset mid-operation: all state clears asynchronously; no redirect is emitted.
- A result consumed and a new operation accepted in the same cycle is a legal back-to-back transfer, giving full throughput per channel.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Two 32-bit saturating counters, stat_resolved and stat_mispred, added as outputs.
  - Counted at the edge where an operation is loaded into an output register; squashed operations are not counted.
  - stat_mispred counts loaded operations with mispredict set.
  - Counters reset to 0 and are unaffected by flush.
- Undefined: the ports and logic are absent.

Test Plan:
- Channel 0 BEQ, src1 = src2 = 5, pred_taken = 1, pred_target = br_target = 0x100, pc = 0x40 -> next cycle res_taken = 1, res_target = 0x100, res_mispred = 0, redirect_valid = 0.
- Channel 1 JALR, src1 = 0x2000, pc = 0x80, pred_target = 0x1FFC, pred_taken = 1 -> res_link = 0x88, res_link_we = 1, res_mispred = 1, redirect_pc = 0x2000 for one cycle.
- rob_head = 120:
  - stimulus: channel 0 tag 3 mispredicted, channel 1 tag 125 mispredicted, same cycle;
  - response: redirect_rob_idx = 125; channel 0 is dropped, res_valid[0] = 0.
- Channel 0 res_ready = 0 holding tag 10, then channel 1 accepts a mispredicted tag 8 with rob_head = 0 -> channel 0 result cleared at the redirect edge.
- res_ready = 0 for 3 cycles after a result -> in_ready = 0 and the output is stable; after res_ready = 1, a same-cycle consume and accept gives a new result on the next cycle.
- flush asserted while both channels are valid and a mispredict is accepted -> next cycle all res_valid = 0, redirect_valid = 0.
- rst_n pulsed low mid-stall -> outputs are 0 immediately.
- With BRANCH_STATS_EN: 4 resolutions including 1 mispredict -> stat_resolved = 4, stat_mispred = 1.
